// File: rtl/hc800_ram_pkg.sv
// Shared types and constants for the HC800 RAM bus to SDRAM word bridge.
package hc800_ram_pkg;

    localparam int BYTE_ADDR_W = 21;
    localparam int WORD_ADDR_W = 20;
    localparam int WORD_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } bridge_state_t;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam logic [1:0] DS_NONE = 2'b00;
    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    function automatic logic [7:0] lane_byte(input logic [WORD_W-1:0] word, input logic lane);
        return (lane == LANE_HI) ? word[15:8] : word[7:0];
    endfunction

    function automatic logic [1:0] lane_ds(input logic lane);
        return (lane == LANE_HI) ? DS_HI : DS_LO;
    endfunction

endpackage

// File: rtl/ram_word_buffer.sv
// One-word read buffer: full-word fill from SDRAM reads, single-lane
// write-through from bus writes, synchronous clear.
module ram_word_buffer
    import hc800_ram_pkg::*;
(
    input  logic                   clk,
    input  logic                   clr,
    input  logic [WORD_ADDR_W-1:0] lookup_tag,
    output logic                   hit,
    output logic [WORD_W-1:0]      data,
    input  logic                   fill_en,
    input  logic [WORD_ADDR_W-1:0] fill_tag,
    input  logic [WORD_W-1:0]      fill_data,
    input  logic                   lane_wr_en,
    input  logic                   lane_sel,
    input  logic [7:0]             lane_data
);

    logic                   valid_q, valid_d;
    logic [WORD_ADDR_W-1:0] tag_q, tag_d;
    logic [WORD_W-1:0]      data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end else if (lane_wr_en) begin
            if (lane_sel == LANE_HI) begin
                data_d[15:8] = lane_data;
            end else begin
                data_d[7:0] = lane_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit  = valid_q && (tag_q == lookup_tag);
    assign data = data_q;

endmodule

// File: rtl/ram_bus_bridge.sv
// HC800 8-bit bus to 16-bit SDRAM word bridge with fixed-latency reads and
// a one-word write-through read buffer.
//
// state    | meaning
// ST_IDLE  | waiting for bus_enable; buffer hits complete from here
// ST_READ  | sd_oe held for READ_LATENCY cycles, capture on the last
// ST_WRITE | sd_we/sd_oe held for WRITE_CYCLES cycles
// ST_DONE  | bus_ready high for one cycle
module ram_bus_bridge
    import hc800_ram_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                   bus_clk,
    input  logic                   bus_reset,
    input  logic                   bus_enable,
    input  logic                   bus_write,
    input  logic [BYTE_ADDR_W-1:0] bus_address,
    input  logic [7:0]             bus_data_from_master,
    output logic [7:0]             bus_data_to_master,
    output logic                   bus_ready,
    output logic [WORD_ADDR_W-1:0] sd_addr,
    output logic [WORD_W-1:0]      sd_din,
    input  logic [WORD_W-1:0]      sd_dout,
    output logic                   sd_we,
    output logic                   sd_oe,
    output logic [1:0]             sd_ds
);

    localparam logic [7:0] RD_LAST = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WR_LAST = 8'(WRITE_CYCLES - 1);

    bridge_state_t          state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   lane_q, lane_d;
    logic                   ready_q, ready_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   sd_we_q, sd_we_d;
    logic                   sd_oe_q, sd_oe_d;
    logic [1:0]             sd_ds_q, sd_ds_d;
    logic [WORD_ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic [WORD_W-1:0]      sd_din_q, sd_din_d;

    logic [WORD_ADDR_W-1:0] lookup_tag;
    logic                   buf_hit;
    logic [WORD_W-1:0]      buf_data;
    logic                   fill_en;
    logic                   lane_wr_en;

    // IDLE looks up the incoming request; during an access the latched word is used.
    assign lookup_tag = (state_q == ST_IDLE) ? bus_address[BYTE_ADDR_W-1:1] : sd_addr_q;

    ram_word_buffer u_buf (
        .clk        (bus_clk),
        .clr        (bus_reset),
        .lookup_tag (lookup_tag),
        .hit        (buf_hit),
        .data       (buf_data),
        .fill_en    (fill_en),
        .fill_tag   (sd_addr_q),
        .fill_data  (sd_dout),
        .lane_wr_en (lane_wr_en),
        .lane_sel   (lane_q),
        .lane_data  (sd_din_q[7:0])
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        ready_d    = 1'b0;
        rdata_d    = rdata_q;
        sd_we_d    = sd_we_q;
        sd_oe_d    = sd_oe_q;
        sd_ds_d    = sd_ds_q;
        sd_addr_d  = sd_addr_q;
        sd_din_d   = sd_din_q;
        fill_en    = 1'b0;
        lane_wr_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus_enable) begin
                    if (bus_write) begin
                        sd_addr_d = bus_address[BYTE_ADDR_W-1:1];
                        sd_din_d  = {2{bus_data_from_master}};
                        sd_ds_d   = lane_ds(bus_address[0]);
                        sd_we_d   = 1'b1;
                        sd_oe_d   = 1'b1;
                        lane_d    = bus_address[0];
                        cnt_d     = WR_LAST;
                        state_d   = ST_WRITE;
                    end else if (buf_hit) begin
                        rdata_d = lane_byte(buf_data, bus_address[0]);
                        ready_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        sd_addr_d = bus_address[BYTE_ADDR_W-1:1];
                        sd_ds_d   = DS_BOTH;
                        sd_oe_d   = 1'b1;
                        lane_d    = bus_address[0];
                        cnt_d     = RD_LAST;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == 8'd0) begin
                    fill_en = 1'b1;
                    rdata_d = lane_byte(sd_dout, lane_q);
                    sd_oe_d = 1'b0;
                    sd_ds_d = DS_NONE;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_WRITE: begin
                if (cnt_q == 8'd0) begin
                    lane_wr_en = buf_hit;
                    sd_we_d    = 1'b0;
                    sd_oe_d    = 1'b0;
                    sd_ds_d    = DS_NONE;
                    ready_d    = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lane_q    <= LANE_LO;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            sd_we_q   <= 1'b0;
            sd_oe_q   <= 1'b0;
            sd_ds_q   <= DS_NONE;
            sd_addr_q <= '0;
            sd_din_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            sd_we_q   <= sd_we_d;
            sd_oe_q   <= sd_oe_d;
            sd_ds_q   <= sd_ds_d;
            sd_addr_q <= sd_addr_d;
            sd_din_q  <= sd_din_d;
        end
    end

    assign bus_ready          = ready_q;
    assign bus_data_to_master = rdata_q;
    assign sd_we              = sd_we_q;
    assign sd_oe              = sd_oe_q;
    assign sd_ds              = sd_ds_q;
    assign sd_addr            = sd_addr_q;
    assign sd_din             = sd_din_q;

endmodule
